sram_like_slave_mem: RTL and testbench

Word-organised memory that acts as the responder end of the sram-like request/addr_ok/data_ok interface driven by the instruction and data caches. It accepts one transaction at a time, applies configurable address-acceptance and data-return latencies, and performs size-aware byte-lane writes. It serves as the memory behind a cache in standalone cache benches. It can also stand in for the AXI bridge in SoC bring-up.

---
 rtl/sram_like_slave_mem_if.sv | 21 ++
 rtl/sram_like_slave_mem.sv | 104 ++++++++++
 tb/tb_sram_like_slave_mem.sv | 323 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_like_slave_mem_if.sv
// Request/addr_ok/data_ok bus between a cache-side requester and the memory responder.
interface sram_like_slave_mem_if;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        addr_ok;
  logic        data_ok;

  modport master (
    output req, wr, size, addr, wdata,
    input  rdata, addr_ok, data_ok
  );

  modport slave (
    input  req, wr, size, addr, wdata,
    output rdata, addr_ok, data_ok
  );
endinterface

// File: rtl/sram_like_slave_mem.sv
// Single-outstanding word memory answering the sram-like bus with configurable
// address-accept delay and read/write completion latencies.
module sram_like_slave_mem #(
  parameter int ADDR_WIDTH    = 12,
  parameter int READ_LATENCY  = 2,
  parameter int WRITE_LATENCY = 1,
  parameter int ADDR_OK_DELAY = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  sram_like_slave_mem_if.slave bus
);

  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic [15:0] RD_LOAD  = 16'(READ_LATENCY - 1);
  localparam logic [15:0] WR_LOAD  = 16'(WRITE_LATENCY - 1);
  localparam logic [3:0]  DLY_MAX  = 4'(ADDR_OK_DELAY);

  logic [31:0] mem [2**ADDR_WIDTH];

  state_t                  state;
  logic [15:0]             cnt;
  logic [3:0]              dly;
  logic                    op_wr;
  logic [1:0]              op_size;
  logic [1:0]              op_lo;
  logic [ADDR_WIDTH-1:0]   op_idx;
  logic [31:0]             op_wdata;
  logic [31:0]             rdata_q;
  logic [3:0]              be;
  logic [ADDR_WIDTH-1:0]   idx;
  logic                    unused_addr;

  // Upper address bits alias onto the same words.
  assign idx         = bus.addr[ADDR_WIDTH+1:2];
  assign unused_addr = &{1'b0, bus.addr[31:ADDR_WIDTH+2]};

  assign bus.addr_ok = !rst && (state == IDLE) && bus.req && (dly == DLY_MAX);
  assign bus.data_ok = !rst && (state == BUSY) && (cnt == '0);
  assign bus.rdata   = rdata_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      dly      <= '0;
      rdata_q  <= '0;
      op_wr    <= 1'b0;
      op_size  <= '0;
      op_lo    <= '0;
      op_idx   <= '0;
      op_wdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.addr_ok) begin
            op_wr    <= bus.wr;
            op_size  <= bus.size;
            op_lo    <= bus.addr[1:0];
            op_idx   <= idx;
            op_wdata <= bus.wdata;
            cnt      <= bus.wr ? WR_LOAD : RD_LOAD;
            if (!bus.wr) rdata_q <= mem[idx];
            dly      <= '0;
            state    <= BUSY;
          end else if (bus.req) begin
            if (dly != DLY_MAX) dly <= dly + 4'd1;
          end else begin
            dly <= '0;
          end
        end
        BUSY: begin
          if (cnt == '0) begin
            state <= IDLE;
            dly   <= '0;
          end else begin
            cnt <= cnt - 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    be = '0;
    case (op_size)
      2'd0:    be[op_lo] = 1'b1;
      2'd1:    be = op_lo[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
  end

  // data_ok is already gated by rst, so an abandoned write never lands.
  always_ff @(posedge clk) begin
    if (bus.data_ok && op_wr) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[op_idx][8*i +: 8] <= op_wdata[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_sram_like_slave_mem.sv
// Two memory instances with different timing parameters, driven by directed and random
// transactions and checked every cycle against a transaction-level model.
module tb_sram_like_slave_mem;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  localparam int RL [2] = '{2, 2};
  localparam int WL [2] = '{1, 3};
  localparam int DL [2] = '{0, 2};

  logic        r_rst   [2];
  logic        d_req   [2];
  logic        d_wr    [2];
  logic [1:0]  d_size  [2];
  logic [31:0] d_addr  [2];
  logic [31:0] d_wdata [2];
  logic        m_ao    [2];
  logic        m_do    [2];
  logic [31:0] m_rd    [2];

  sram_like_slave_mem_if if0 ();
  sram_like_slave_mem_if if1 ();

  assign if0.req = d_req[0];  assign if0.wr = d_wr[0];  assign if0.size = d_size[0];
  assign if0.addr = d_addr[0];  assign if0.wdata = d_wdata[0];
  assign if1.req = d_req[1];  assign if1.wr = d_wr[1];  assign if1.size = d_size[1];
  assign if1.addr = d_addr[1];  assign if1.wdata = d_wdata[1];
  assign m_ao[0] = if0.addr_ok;  assign m_do[0] = if0.data_ok;  assign m_rd[0] = if0.rdata;
  assign m_ao[1] = if1.addr_ok;  assign m_do[1] = if1.data_ok;  assign m_rd[1] = if1.rdata;

  sram_like_slave_mem #(.ADDR_WIDTH(12), .READ_LATENCY(2), .WRITE_LATENCY(1), .ADDR_OK_DELAY(0))
    dut0 (.clk(clk), .rst(r_rst[0]), .bus(if0));
  sram_like_slave_mem #(.ADDR_WIDTH(12), .READ_LATENCY(2), .WRITE_LATENCY(3), .ADDR_OK_DELAY(2))
    dut1 (.clk(clk), .rst(r_rst[1]), .bus(if1));

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d cycle %0d: got %h expected %h", nm, k, cyc, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input int k, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d cycle %0d: got %b expected %b", nm, k, cyc, act, exp);
    end
  endtask

  task automatic timeout_fail(input string nm, input int k);
    n_checks++;
    n_fail++;
    $display("FAIL %s dut%0d timeout at cycle %0d: got no response expected one", nm, k, cyc);
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] mm [2][4096];
  bit          busy   [2];
  int          done_c [2];
  int          run    [2];
  logic        pw_wr  [2];
  logic [1:0]  pw_sz  [2];
  logic [1:0]  pw_lo  [2];
  int          pw_idx [2];
  logic [31:0] pw_wd  [2];
  logic [31:0] mrd    [2];

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [1:0] sz, input logic [1:0] lo);
    logic [31:0] r;
    int first, n;
    r = old;
    case (sz)
      2'd0:    begin first = int'(lo);         n = 1; end
      2'd1:    begin first = lo[1] ? 2 : 0;    n = 2; end
      default: begin first = 0;                n = 4; end
    endcase
    for (int i = first; i < first + n; i++) r[8*i +: 8] = wd[8*i +: 8];
    return r;
  endfunction

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (r_rst[k]) begin
        chk1("reset addr_ok", k, m_ao[k], 1'b0);
        chk1("reset data_ok", k, m_do[k], 1'b0);
        chk("reset rdata", k, m_rd[k], 32'h0);
        busy[k] = 1'b0;
        run[k]  = 0;
        mrd[k]  = 32'h0;
      end else begin
        bit eao, edo;
        eao = !busy[k] && d_req[k] && (run[k] >= DL[k]);
        edo = busy[k] && (cyc == done_c[k]);
        chk1("addr_ok", k, m_ao[k], eao);
        chk1("data_ok", k, m_do[k], edo);
        if (!busy[k] || edo) chk("rdata", k, m_rd[k], mrd[k]);
        if (edo) begin
          if (pw_wr[k]) mm[k][pw_idx[k]] = merge(mm[k][pw_idx[k]], pw_wd[k], pw_sz[k], pw_lo[k]);
          busy[k] = 1'b0;
          run[k]  = 0;
        end else if (busy[k]) begin
          run[k] = 0;
        end else if (eao) begin
          busy[k]   = 1'b1;
          done_c[k] = cyc + (d_wr[k] ? WL[k] : RL[k]);
          pw_wr[k]  = d_wr[k];
          pw_sz[k]  = d_size[k];
          pw_lo[k]  = d_addr[k][1:0];
          pw_idx[k] = int'(d_addr[k][13:2]);
          pw_wd[k]  = d_wdata[k];
          if (!d_wr[k]) mrd[k] = mm[k][pw_idx[k]];
          run[k]    = 0;
        end else begin
          run[k] = d_req[k] ? run[k] + 1 : 0;
        end
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic wait_dok(input int k, output int dn, output logic [31:0] rd);
    dn = -1;
    rd = 32'h0;
    for (int t = 0; t < 60; t++) begin
      @(negedge clk); #1;
      if (m_do[k]) begin
        dn = cyc;
        rd = m_rd[k];
        break;
      end
      @(posedge clk); #1;
    end
    if (dn < 0) timeout_fail("data_ok wait", k);
  endtask

  task automatic txn(input int k, input logic w, input logic [1:0] sz, input logic [31:0] a,
                     input logic [31:0] wd, input bit keep,
                     output int hs, output int dn, output logic [31:0] rd);
    @(posedge clk); #1;
    d_req[k] = 1'b1; d_wr[k] = w; d_size[k] = sz; d_addr[k] = a; d_wdata[k] = wd;
    hs = -1;
    dn = -1;
    rd = 32'h0;
    for (int t = 0; t < 60; t++) begin
      @(negedge clk); #1;
      if (m_ao[k]) begin
        hs = cyc;
        break;
      end
      @(posedge clk); #1;
    end
    if (hs < 0) begin
      timeout_fail("addr_ok wait", k);
      d_req[k] = 1'b0;
      return;
    end
    @(posedge clk); #1;
    // Fields are scrambled after the handshake; the memory must use its latched copy.
    d_req[k]   = keep;
    d_addr[k]  = $urandom;
    d_wdata[k] = $urandom;
    d_wr[k]    = 1'($urandom_range(0, 1));
    d_size[k]  = 2'($urandom_range(0, 3));
    wait_dok(k, dn, rd);
  endtask

  int hs, dn, hs2, dn2, c0, first, ndok;
  logic [31:0] rd, rd2;
  logic ao_seen [3];
  bit keep, prev_keep;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int k = 0; k < 2; k++) begin
      r_rst[k] = 1'b1; d_req[k] = 1'b0; d_wr[k] = 1'b0; d_size[k] = 2'd0;
      d_addr[k] = 32'h0; d_wdata[k] = 32'h0;
    end
    repeat (3) @(posedge clk);
    #1;
    r_rst[0] = 1'b0;
    r_rst[1] = 1'b0;

    // Preload the 32-word window used by every test.
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 32; i++)
        txn(k, 1'b1, 2'd2, 32'(i) << 2, $urandom, 1'b0, hs, dn, rd);

    // Word round trip.
    txn(0, 1'b1, 2'd2, 32'h10, 32'hDEADBEEF, 1'b0, hs, dn, rd);
    chk("write latency", 0, 32'(dn - hs), 32'd1);
    txn(0, 1'b0, 2'd2, 32'h10, 32'h0, 1'b0, hs2, dn2, rd);
    chk("read follows write", 0, 32'(hs2 - dn), 32'd1);
    chk("read latency", 0, 32'(dn2 - hs2), 32'd2);
    chk("round trip data", 0, rd, 32'hDEADBEEF);

    // Partial writes.
    txn(0, 1'b1, 2'd2, 32'h20, 32'h11223344, 1'b0, hs, dn, rd);
    txn(0, 1'b1, 2'd0, 32'h23, 32'hAA000000, 1'b0, hs, dn, rd);
    txn(0, 1'b0, 2'd2, 32'h20, 32'h0, 1'b0, hs, dn, rd);
    chk("byte write", 0, rd, 32'hAA223344);
    txn(0, 1'b1, 2'd1, 32'h20, 32'h00005566, 1'b0, hs, dn, rd);
    txn(0, 1'b0, 2'd2, 32'h20, 32'h0, 1'b0, hs, dn, rd);
    chk("half write", 0, rd, 32'hAA225566);
    txn(0, 1'b1, 2'd3, 32'h22, 32'h01020304, 1'b0, hs, dn, rd);
    txn(0, 1'b0, 2'd2, 32'h20, 32'h0, 1'b0, hs, dn, rd);
    chk("size3 write", 0, rd, 32'h01020304);

    // Back-to-back reads with req held.
    txn(0, 1'b0, 2'd2, 32'h10, 32'h0, 1'b1, hs, dn, rd);
    txn(0, 1'b0, 2'd2, 32'h20, 32'h0, 1'b0, hs2, dn2, rd2);
    chk("b2b addr_ok", 0, 32'(hs2 - dn), 32'd1);
    chk("b2b data 1", 0, rd, 32'hDEADBEEF);
    chk("b2b data 2", 0, rd2, 32'h01020304);

    // Aliasing.
    txn(0, 1'b1, 2'd2, 32'h4010, 32'h12345678, 1'b0, hs, dn, rd);
    txn(0, 1'b0, 2'd2, 32'h0010, 32'h0, 1'b0, hs, dn, rd);
    chk("alias read", 0, rd, 32'h12345678);

    // addr_ok delay of 2.
    @(posedge clk); #1;
    d_req[1] = 1'b1; d_wr[1] = 1'b0; d_size[1] = 2'd2; d_addr[1] = 32'h10;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      ao_seen[i] = m_ao[1];
      if (i < 2) begin @(posedge clk); #1; end
    end
    chk1("delay cycle 0", 1, ao_seen[0], 1'b0);
    chk1("delay cycle 1", 1, ao_seen[1], 1'b0);
    chk1("delay cycle 2", 1, ao_seen[2], 1'b1);
    @(posedge clk); #1;
    d_req[1] = 1'b0;
    wait_dok(1, dn, rd);

    // Dropped request restarts the delay count.
    @(posedge clk); #1;
    d_req[1] = 1'b1; d_addr[1] = 32'h20; c0 = cyc;
    @(posedge clk); #1;
    d_req[1] = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    d_req[1] = 1'b1;
    first = -1;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk); #1;
      if (m_ao[1]) begin first = cyc; break; end
      @(posedge clk); #1;
    end
    chk("delay restart", 1, 32'(first - c0), 32'd5);
    @(posedge clk); #1;
    d_req[1] = 1'b0;
    wait_dok(1, dn, rd);

    // Reset in the middle of a 3-cycle write.
    txn(1, 1'b1, 2'd2, 32'h40, 32'h0, 1'b0, hs, dn, rd);
    @(posedge clk); #1;
    d_req[1] = 1'b1; d_wr[1] = 1'b1; d_size[1] = 2'd2; d_addr[1] = 32'h40; d_wdata[1] = 32'hCAFEF00D;
    hs = -1;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk); #1;
      if (m_ao[1]) begin hs = cyc; break; end
      @(posedge clk); #1;
    end
    if (hs < 0) timeout_fail("reset test addr_ok", 1);
    @(posedge clk); #1;
    d_req[1] = 1'b0;
    r_rst[1] = 1'b1;
    @(posedge clk); #1;
    r_rst[1] = 1'b0;
    ndok = 0;
    for (int t = 0; t < 6; t++) begin
      @(negedge clk); #1;
      if (m_do[1]) ndok++;
      @(posedge clk); #1;
    end
    chk("no data_ok after reset", 1, 32'(ndok), 32'd0);
    chk("rdata after reset", 1, m_rd[1], 32'h0);
    txn(1, 1'b0, 2'd2, 32'h40, 32'h0, 1'b0, hs, dn, rd);
    chk("abandoned write", 1, rd, 32'h0);

    // Random traffic on both instances.
    for (int k = 0; k < 2; k++) begin
      prev_keep = 1'b0;
      for (int i = 0; i < 150; i++) begin
        logic [31:0] a;
        a = ($urandom & 32'hFFFF_C000) | (32'($urandom_range(0, 31)) << 2) |
            32'($urandom_range(0, 3));
        keep = (i < 149) && ($urandom_range(0, 2) == 0);
        if (!prev_keep && k == 1 && $urandom_range(0, 3) == 0) begin
          @(posedge clk); #1;
          d_req[1] = 1'b1;
          @(posedge clk); #1;
          d_req[1] = 1'b0;
        end
        txn(k, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), a, $urandom, keep,
            hs, dn, rd);
        if (!keep) repeat ($urandom_range(0, 2)) @(posedge clk);
        prev_keep = keep;
      end
      d_req[k] = 1'b0;
    end
    repeat (4) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
